// File: rtl/mcpu_vram_dma_pkg.sv
// VRAM DMA shared definitions: VRAM geometry, GPU control-register map
// and the DMA state encoding.
package mcpu_vram_dma_pkg;

    localparam int VRAM_SIZE = 8192;
    localparam int ADDR_W    = 13;
    localparam int DATA_W    = 8;

    typedef logic [ADDR_W-1:0] vaddr_t;
    typedef logic [DATA_W-1:0] vdata_t;

    // The top four VRAM bytes double as GPU control registers.
    localparam vaddr_t REG_CTRL0    = 13'd8188;
    localparam vaddr_t REG_CTRL1    = 13'd8189;
    localparam vaddr_t REG_GPU_MODE = 13'd8190;
    localparam vaddr_t REG_GPU_CFG  = 13'd8191;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_FILL,
        ST_DONE
    } state_t;

    function automatic vaddr_t addr_inc(vaddr_t a);
        return a + vaddr_t'(1);
    endfunction

    function automatic state_t first_state(vaddr_t len, logic copy);
        if (len == '0) return ST_DONE;
        return copy ? ST_RD : ST_FILL;
    endfunction

endpackage

// File: rtl/mcpu_vram_dma_if.sv
// Host/VRAM-port bundle for the VRAM DMA engine.
// master = host side, slave = the DMA block.
interface mcpu_vram_dma_if;
    import mcpu_vram_dma_pkg::*;

    logic   start;
    logic   abort;
    logic   mode;
    vaddr_t src_addr;
    vaddr_t dst_addr;
    vaddr_t length;
    vdata_t fill_value;
    logic   display_on;
    logic   busy;
    logic   done;
    vaddr_t vram_addr;
    logic   vram_re;
    logic   vram_we;

    modport master (
        output start, abort, mode, src_addr, dst_addr, length,
        output fill_value, display_on,
        input  busy, done, vram_addr, vram_re, vram_we
    );

    modport slave (
        input  start, abort, mode, src_addr, dst_addr, length,
        input  fill_value, display_on,
        output busy, done, vram_addr, vram_re, vram_we
    );

endinterface

// File: rtl/mcpu_vram_dma.sv
// VRAM DMA engine: byte fill and forward copy over the GPU VRAM port,
// optionally restricted to display blanking.
module mcpu_vram_dma
    import mcpu_vram_dma_pkg::*;
#(
    parameter int BLANK_ONLY = 0
) (
    input  logic              clk,
    input  logic              reset,
    mcpu_vram_dma_if.slave    bus,
    inout  wire  [DATA_W-1:0] data_bus
);

    state_t state, nxt;
    vaddr_t src_ptr, dst_ptr, count;
    logic   mode_q;
    vdata_t fill_q, rdata, wdata;
    logic   go, re, we;

    // Active display blocks all VRAM traffic when blank-only is set.
    assign go = !((BLANK_ONLY != 0) && bus.display_on);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (bus.start)
                    nxt = first_state(bus.length, bus.mode);
            end
            ST_RD: begin
                if (bus.abort)  nxt = ST_DONE;
                else if (go)    nxt = ST_WR;
            end
            ST_WR: begin
                if (bus.abort)  nxt = ST_DONE;
                else if (go)
                    nxt = (count == vaddr_t'(1)) ? ST_DONE : ST_RD;
            end
            ST_FILL: begin
                if (bus.abort)  nxt = ST_DONE;
                else if (go && count == vaddr_t'(1))
                    nxt = ST_DONE;
            end
            ST_DONE: nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        re            = 1'b0;
        we            = 1'b0;
        bus.vram_addr = '0;
        unique case (state)
            ST_RD: begin
                re            = go;
                bus.vram_addr = src_ptr;
            end
            ST_WR, ST_FILL: begin
                we            = go;
                bus.vram_addr = dst_ptr;
            end
            default: ;
        endcase
        bus.vram_re = re;
        bus.vram_we = we;
        bus.busy    = (state != ST_IDLE);
        bus.done    = (state == ST_DONE);
    end

    assign wdata    = mode_q ? rdata : fill_q;
    assign data_bus = we ? wdata : 'z;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_ptr <= '0;
            dst_ptr <= '0;
            count   <= '0;
            mode_q  <= 1'b0;
            fill_q  <= '0;
            rdata   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        src_ptr <= bus.src_addr;
                        dst_ptr <= bus.dst_addr;
                        count   <= bus.length;
                        mode_q  <= bus.mode;
                        fill_q  <= bus.fill_value;
                    end
                end
                ST_RD: begin
                    if (go) rdata <= data_bus;
                end
                ST_WR: begin
                    if (go) begin
                        src_ptr <= addr_inc(src_ptr);
                        dst_ptr <= addr_inc(dst_ptr);
                        count   <= count - vaddr_t'(1);
                    end
                end
                ST_FILL: begin
                    if (go) begin
                        dst_ptr <= addr_inc(dst_ptr);
                        count   <= count - vaddr_t'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
